// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus of the PC sequencer: instruction memory req/ack plus the valid/ready path to decode.
interface pc_fetch_sequencer_if #(
  parameter int PC_W = 32
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr_out;
  logic [PC_W-1:0] pc_out;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_out, pc_out,
    input  imem_ack, imem_data, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_out, pc_out,
    output imem_ack, imem_data, instr_ready
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// KGP-RISC PC/fetch sequencer; BRANCH_COUNT_EN adds a saturating taken-branch counter.
// Latency: instruction presented the cycle after imem_ack (min 1 cycle from req).
// Backpressure: holds one instruction until instr_ready; no new fetch is issued while holding.
module pc_fetch_sequencer #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_valid,
  input  logic              branch,
  input  logic [25:0]       offset_in,
  input  logic              jump_reg,
  input  logic [PC_W-1:0]   rs_value,
  input  logic [PC_W-1:0]   branch_pc,
  pc_fetch_sequencer_if.master bus,
  output logic [PC_W-1:0]   link_pc
`ifdef BRANCH_COUNT_EN
  ,output logic [15:0]      taken_count
`endif
);

  localparam logic [1:0] FETCH    = 2'd0;
  localparam logic [1:0] HOLD     = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  logic [1:0]      state;
  logic            started;
  logic            flush_pending;
  logic [PC_W-1:0] pc;
  logic            taken;
  logic            fetch_req;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] rel_target;
  logic [PC_W-1:0] target_raw;
  logic [PC_W-1:0] target;

  assign taken = branch_valid & branch;

  always_comb begin
    seq_pc     = branch_pc + PC_W'(4);
    rel_target = seq_pc + {{(PC_W-28){offset_in[25]}}, offset_in, 2'b00};
    target_raw = jump_reg ? rs_value : rel_target;
    target     = {target_raw[PC_W-1:2], 2'b00};
  end

  // started keeps req low through the first edge after reset, so a stray ack there is ignored
  assign fetch_req     = started && (state == FETCH);
  assign bus.imem_req  = fetch_req;
  assign bus.imem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= FETCH;
      started         <= 1'b0;
      flush_pending   <= 1'b0;
      pc              <= RESET_PC;
      link_pc         <= '0;
      bus.instr_valid <= 1'b0;
      bus.instr_out   <= '0;
      bus.pc_out      <= '0;
    end else begin
      started <= 1'b1;
      if (taken) begin
        pc              <= target;
        link_pc         <= seq_pc;
        bus.instr_valid <= 1'b0;
        case (state)
          FETCH: begin
            if (fetch_req && !bus.imem_ack) begin
              state         <= REDIRECT;
              flush_pending <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
          // an ack landing with the re-branch retires the stale fetch, so REDIRECT cannot stall
          REDIRECT: begin
            if (bus.imem_ack) begin
              state         <= FETCH;
              flush_pending <= 1'b0;
            end
          end
          default: state <= FETCH;
        endcase
      end else begin
        case (state)
          FETCH: begin
            if (fetch_req && bus.imem_ack) begin
              bus.instr_out   <= bus.imem_data;
              bus.pc_out      <= pc;
              bus.instr_valid <= 1'b1;
              pc              <= pc + PC_W'(4);
              state           <= HOLD;
            end
          end
          HOLD: begin
            if (bus.instr_ready) begin
              bus.instr_valid <= 1'b0;
              state           <= FETCH;
            end
          end
          REDIRECT: begin
            if (bus.imem_ack && flush_pending) begin
              state         <= FETCH;
              flush_pending <= 1'b0;
            end
          end
          default: begin
            state         <= FETCH;
            flush_pending <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef BRANCH_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken_count <= '0;
    end else if (taken && (taken_count != 16'hFFFF)) begin
      taken_count <= taken_count + 16'd1;
    end
  end
`endif

endmodule
